// File: rtl/gnn_aggregator.sv
// Four-node GNN neighbourhood aggregator: collects one feature vector per node,
// sums them per destination under an adjacency mask, and emits saturated results.
module gnn_aggregator #(
  parameter int SELF_LOOP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [15:0]         adj,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_node,
  input  logic signed [12:0]  in_y4,
  input  logic signed [12:0]  in_y5,
  input  logic signed [12:0]  in_y6,
  input  logic signed [12:0]  in_y7,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_node,
  output logic signed [12:0]  y4_aggr,
  output logic signed [12:0]  y5_aggr,
  output logic signed [12:0]  y6_aggr,
  output logic signed [12:0]  y7_aggr,
  output logic                busy
);

  typedef enum logic [1:0] {COLLECT, ACCUM, EMIT} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         mask_reg;
  logic [15:0]        adj_reg;
  logic [1:0]         src_reg;
  logic [1:0]         node_reg;
  logic signed [12:0] feat_reg [4][4];
  logic signed [12:0] in_vec   [4];
  logic signed [14:0] acc_all  [4][4];
  logic signed [12:0] y_sel    [4];
  logic               pass_done;

  assign in_vec[0] = in_y4;
  assign in_vec[1] = in_y5;
  assign in_vec[2] = in_y6;
  assign in_vec[3] = in_y7;

  assign in_ready  = (state_reg == COLLECT);
  assign out_valid = (state_reg == EMIT);
  assign busy      = (state_reg != COLLECT);
  assign out_node  = node_reg;
  assign pass_done = (state_reg == EMIT) && out_ready && (node_reg == 2'd3);

  function automatic logic signed [12:0] sat13(input logic signed [14:0] v);
    if (v > 15'sd4095)
      return 13'sd4095;
    else if (v < -15'sd4096)
      return -13'sd4096;
    else
      return v[12:0];
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (mask_reg == 4'hF) state_next = ACCUM;
      ACCUM:   if (src_reg == 2'd3) state_next = EMIT;
      EMIT:    if (pass_done) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
    if (flush) state_next = COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      mask_reg  <= '0;
      adj_reg   <= '0;
      src_reg   <= '0;
      node_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        mask_reg <= '0;
        src_reg  <= '0;
        node_reg <= '0;
      end else begin
        case (state_reg)
          COLLECT: begin
            if (in_valid) mask_reg <= mask_reg | (4'b0001 << in_node);
            // adjacency is frozen on the edge that enters ACCUM
            if (mask_reg == 4'hF) begin
              adj_reg <= adj;
              src_reg <= '0;
            end
          end
          ACCUM: src_reg <= src_reg + 2'd1;
          EMIT: begin
            if (out_ready) node_reg <= node_reg + 2'd1;
            if (pass_done) mask_reg <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Feature slots need no reset: a pass only starts once every slot is rewritten.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready && !flush) begin
      for (int f = 0; f < 4; f++) feat_reg[in_node][f] <= in_vec[f];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dst
    logic [3:0] row;
    logic       hit;
    assign row = adj_reg[gi*4 +: 4];
    assign hit = row[src_reg] || ((SELF_LOOP != 0) && (src_reg == 2'(gi)));

    for (genvar gj = 0; gj < 4; gj++) begin : g_feat
      logic signed [14:0] acc_reg;
      logic signed [12:0] add_val;
      assign add_val = feat_reg[src_reg][gj];
      assign acc_all[gi][gj] = acc_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          acc_reg <= '0;
        else if (flush || pass_done)
          acc_reg <= '0;
        else if (state_reg == ACCUM && hit)
          acc_reg <= acc_reg + $signed({{2{add_val[12]}}, add_val});
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_out
    assign y_sel[gi] = (state_reg == EMIT) ? sat13(acc_all[node_reg][gi]) : '0;
  end

  assign y4_aggr = y_sel[0];
  assign y5_aggr = y_sel[1];
  assign y6_aggr = y_sel[2];
  assign y7_aggr = y_sel[3];

endmodule

// File: tb/tb_gnn_aggregator.sv
// Randomized and directed bench for gnn_aggregator; two instances cover
// SELF_LOOP=0 (index 0) and SELF_LOOP=1 (index 1) with shared stimulus.
module tb_gnn_aggregator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, flush, in_valid, out_ready;
  logic [15:0]        adj;
  logic [1:0]         in_node;
  logic signed [12:0] in_y [4];
  logic [1:0]         in_ready_o, out_valid_o, busy_o;
  logic [1:0]         out_node_o [2];
  logic signed [12:0] y_o [2][4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;
  int feats [4][4];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    gnn_aggregator #(.SELF_LOOP(gi)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .adj(adj),
      .in_valid(in_valid), .in_ready(in_ready_o[gi]), .in_node(in_node),
      .in_y4(in_y[0]), .in_y5(in_y[1]), .in_y6(in_y[2]), .in_y7(in_y[3]),
      .out_valid(out_valid_o[gi]), .out_ready(out_ready), .out_node(out_node_o[gi]),
      .y4_aggr(y_o[gi][0]), .y5_aggr(y_o[gi][1]), .y6_aggr(y_o[gi][2]), .y7_aggr(y_o[gi][3]),
      .busy(busy_o[gi])
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sum of contributing sources, then clamp to the 13-bit range.
  function automatic int expect_val(input int sl, input int d, input int f);
    int sum = 0;
    for (int s = 0; s < 4; s++)
      if (adj[d*4+s] || (sl != 0 && d == s)) sum += feats[s][f];
    if (sum > 4095) sum = 4095;
    if (sum < -4096) sum = -4096;
    return sum;
  endfunction

  task automatic send(input int n, input int a, input int b, input int c, input int e);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_node  = n[1:0];
    in_y[0] = a[12:0]; in_y[1] = b[12:0]; in_y[2] = c[12:0]; in_y[3] = e[12:0];
    while (!in_ready_o[0] && w < 50) begin @(negedge clk); w++; end
    if (w == 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    feats[n][0] = a; feats[n][1] = b; feats[n][2] = c; feats[n][3] = e;
    t_last = cyc;
    $display("send node=%0d y=%0d,%0d,%0d,%0d", n, a, b, c, e);
  endtask

  task automatic check_node(input int k);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid[%0d]", i), int'(out_valid_o[i]), 1);
      check($sformatf("out_node[%0d]", i), int'(out_node_o[i]), k);
      for (int f = 0; f < 4; f++)
        check($sformatf("y%0d_aggr[%0d] node%0d", f + 4, i, k), int'(y_o[i][f]), expect_val(i, k, f));
    end
  endtask

  task automatic drain(input int stall_node);
    int w = 0;
    @(negedge clk);
    while (!out_valid_o[0] && w < 40) begin @(negedge clk); w++; end
    if (w == 40) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc - t_last, 5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check_node(k);
      if (k == stall_node) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_node(k);
        end
        out_ready = 1'b1;
      end
      $display("emit node=%0d sl0 y=%0d,%0d,%0d,%0d sl1 y=%0d,%0d,%0d,%0d", k,
               y_o[0][0], y_o[0][1], y_o[0][2], y_o[0][3],
               y_o[1][0], y_o[1][1], y_o[1][2], y_o[1][3]);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready_after[%0d]", i), int'(in_ready_o[i]), 1);
      check($sformatf("busy_after[%0d]", i), int'(busy_o[i]), 0);
      check($sformatf("out_valid_after[%0d]", i), int'(out_valid_o[i]), 0);
    end
  endtask

  function automatic int rnd_feat();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic send_rnd(input int n);
    send(n, rnd_feat(), rnd_feat(), rnd_feat(), rnd_feat());
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s out_valid[%0d]", tag, i), int'(out_valid_o[i]), 0);
      check($sformatf("%s busy[%0d]", tag, i), int'(busy_o[i]), 0);
    end
  endtask

  // Abort at ACCUM cycle 2 by flush (mode 0) or reset (mode 1), then a fresh pass.
  task automatic abort_pass(input int mode);
    adj = 16'(($urandom));
    for (int n = 0; n < 4; n++) send_rnd(n);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_accum", int'(busy_o[0]), 1);
    if (mode == 0) flush = 1'b1; else rst_n = 1'b0;
    if (mode == 1) begin
      #1;
      check_idle("reset_now");
      for (int f = 0; f < 4; f++) check($sformatf("reset_y%0d", f + 4), int'(y_o[1][f]), 0);
    end
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_idle(mode == 0 ? "post_flush" : "post_reset");
    end
    $display("abort mode=%0d done", mode);
    send_rnd(0); send_rnd(1); send_rnd(2);
    repeat (4) @(negedge clk);
    check("mask_cleared_busy", int'(busy_o[0]), 0);
    send_rnd(3);
    drain(-1);
  endtask

  initial begin
    int ord [4];
    int tmp, j;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    adj = '0; in_node = '0;
    for (int f = 0; f < 4; f++) in_y[f] = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_out_node", int'(out_node_o[0]), 0);
    check("reset_y4", int'(y_o[0][0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", int'(in_ready_o[0]), 1);

    // identity via self loop only; SELF_LOOP=0 instance must emit zeros
    adj = 16'h0000;
    send(0, 10, 1, -2, 3); send(1, 20, 4, 5, -6); send(2, 30, 7, 8, 9); send(3, 40, -1, 0, 2);
    drain(-1);

    // saturation both ways
    adj = 16'hFFFF;
    for (int n = 0; n < 4; n++) send(n, 4095, 4095, 4095, 4095);
    drain(-1);
    for (int n = 0; n < 4; n++) send(n, -4096, -4096, -4096, -4096);
    drain(-1);

    // ring: destination d fed by d-1
    adj = '0;
    for (int d = 0; d < 4; d++) adj[d*4 + ((d + 3) % 4)] = 1'b1;
    for (int n = 0; n < 4; n++) send(n, 0, n + 1, 0, 0);
    drain(-1);

    // repeated node: ACCUM only after the last distinct node, later write wins
    adj = 16'h1248;
    send(2, 5, 5, 5, 5);
    send(2, 7, 7, 7, 7);
    send(0, 100, -3, 11, 0);
    send(1, -50, 2, 13, 1);
    repeat (3) @(negedge clk);
    check("repeat_still_collect", int'(busy_o[0]), 0);
    send(3, 9, 9, -9, 9);
    @(negedge clk);
    check("accum_not_yet", int'(busy_o[0]), 0);
    @(negedge clk);
    check("accum_entered", int'(busy_o[0]), 1);
    drain(-1);

    // back-pressure at out_node 1
    adj = 16'(($urandom));
    for (int n = 0; n < 4; n++) send_rnd(n);
    drain(1);

    abort_pass(0);
    abort_pass(1);

    // randomized passes: random order, adjacency, and stall position
    for (int p = 0; p < 10; p++) begin
      adj = 16'(($urandom));
      for (int i = 0; i < 4; i++) ord[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      if ((p % 3) == 0) send_rnd(ord[1]);
      for (int i = 0; i < 4; i++) send_rnd(ord[i]);
      drain(int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
